// File: rtl/cyclic_decoder_systematic.sv
`default_nettype none
// ============================================================================
//  Module   : cyclic_decoder_systematic
//  Purpose  : Bit-serial decoder for the systematic (15,11) cyclic code with
//             generator g(x) = x^4 + x + 1. Collects a 15-bit codeword
//             (c14 first), computes its syndrome on the fly, corrects any
//             single-bit error and streams out the 11 info bits (c14..c4).
//  Ports    : clk, reset     - clock (rising edge) / synchronous active-high reset
//             in_valid/in_ready/in_bit      - serial code-bit input handshake
//             out_valid/out_ready/out_bit   - serial corrected info-bit output
//             out_last      - marks the 11th info bit of a frame
//             err_flag      - frame syndrome was nonzero (valid with out_valid)
//             err_pos[3:0]  - corrected bit position (valid with err_flag)
//             err_count[15:0] - saturating count of corrected frames
//                               (present only with CYC_DEC_ERR_STATS_EN)
//  Options  : CYC_DEC_ERR_STATS_EN - adds the err_count output and counter
//  Revision : 1.0 - initial release
// ============================================================================
module cyclic_decoder_systematic #(
    parameter int         N        = 15,
    parameter int         K        = 11,
    parameter logic [4:0] GEN_POLY = 5'b10011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_bit,
    input  logic        out_ready,
    output logic        out_last,
    output logic        err_flag,
    output logic [3:0]  err_pos
`ifdef CYC_DEC_ERR_STATS_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [3:0] LAST_IN_IDX  = 4'(N - 1);
    localparam logic [3:0] LAST_OUT_IDX = 4'(K - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } emit_state_t;

    // ------------------------------------------------------------------------
    // Collector: shift buffer, bit counter and syndrome LFSR
    // ------------------------------------------------------------------------
    logic [N-1:0] col_buf;
    logic [3:0]   col_cnt;
    logic [3:0]   syn;
    logic         col_full;
    logic         accept;
    logic         transfer;

    assign in_ready = ~reset & ~col_full;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_buf  <= '0;
            col_cnt  <= '0;
            syn      <= '0;
            col_full <= 1'b0;
        end else if (accept) begin
            col_buf <= {col_buf[N-2:0], in_bit};
            // Feeding the codeword MSB first leaves r(x) mod g(x) in syn.
            syn     <= {syn[2:0], in_bit} ^ (syn[3] ? GEN_POLY[3:0] : 4'b0000);
            if (col_cnt == LAST_IN_IDX) begin
                col_cnt  <= '0;
                col_full <= 1'b1;
            end else begin
                col_cnt <= col_cnt + 4'd1;
            end
        end else if (transfer) begin
            // Frame handed to the emitter; start the next syndrome from zero.
            col_full <= 1'b0;
            syn      <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Correction: find p with x^p mod g(x) == syn by walking the powers of x.
    // The powers are distinct for a primitive g(x), so at most one p matches.
    // ------------------------------------------------------------------------
    logic [3:0]   pw;
    logic [3:0]   fix_pos;
    logic         fix_hit;
    logic [K-1:0] info_mask;
    logic [K-1:0] info_fixed;

    always_comb begin
        pw      = 4'b0001;
        fix_pos = '0;
        fix_hit = (syn != 4'b0000);
        for (int p = 0; p < N; p++) begin
            if (pw == syn) begin
                fix_pos = p[3:0];
            end
            pw = {pw[2:0], 1'b0} ^ (pw[3] ? GEN_POLY[3:0] : 4'b0000);
        end
    end

    // Only info positions are forwarded, so a parity-bit error leaves the
    // data untouched while still raising err_flag.
    always_comb begin
        info_mask = '0;
        for (int b = 0; b < K; b++) begin
            info_mask[b] = fix_hit && (fix_pos == 4'(b + N - K));
        end
    end

    assign info_fixed = col_buf[N-1:N-K] ^ info_mask;

    // ------------------------------------------------------------------------
    // Emitter FSM
    // ------------------------------------------------------------------------
    emit_state_t  state;
    emit_state_t  state_next;
    logic [K-1:0] emit_buf;
    logic [3:0]   emit_idx;
    logic         emit_err;
    logic [3:0]   emit_pos;
    logic         out_hs;
    logic         last_hs;

    assign out_valid = (state == EMIT);
    assign out_hs    = out_valid & out_ready;
    assign last_hs   = out_hs & (emit_idx == LAST_OUT_IDX);
    // A pending frame may be loaded in the same cycle the current one ends.
    assign transfer  = col_full & ((state == EMPTY) | last_hs);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (transfer) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (last_hs) begin
                    state_next = transfer ? EMIT : EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            emit_buf <= '0;
            emit_idx <= '0;
            emit_err <= 1'b0;
            emit_pos <= '0;
        end else if (transfer) begin
            emit_buf <= info_fixed;
            emit_idx <= '0;
            emit_err <= fix_hit;
            emit_pos <= fix_pos;
        end else if (out_hs) begin
            emit_buf <= {emit_buf[K-2:0], 1'b0};
            emit_idx <= emit_idx + 4'd1;
        end
    end

    assign out_bit  = out_valid & emit_buf[K-1];
    assign out_last = out_valid & (emit_idx == LAST_OUT_IDX);
    assign err_flag = out_valid & emit_err;
    assign err_pos  = err_flag ? emit_pos : 4'd0;

`ifdef CYC_DEC_ERR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (last_hs && emit_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cyclic_decoder_systematic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cyclic_decoder_systematic
//  Purpose  : Directed self-checking bench for cyclic_decoder_systematic.
//             Drives serial codewords, collects handshaken output bits and
//             compares them against hand-computed expectations.
//  Options  : CYC_DEC_ERR_STATS_EN - also checks the err_count output
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cyclic_decoder_systematic;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic        out_bit;
    logic        out_ready;
    logic        out_last;
    logic        err_flag;
    logic [3:0]  err_pos;
`ifdef CYC_DEC_ERR_STATS_EN
    logic [15:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       b;
        logic       last;
        logic       err;
        logic [3:0] pos;
    } item_t;

    item_t q[$];

    always #5 clk = ~clk;

    cyclic_decoder_systematic dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err_flag  (err_flag),
        .err_pos   (err_pos)
`ifdef CYC_DEC_ERR_STATS_EN
        ,
        .err_count (err_count)
`endif
    );

    // Record every output bit that will handshake on the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q.push_back({out_bit, out_last, err_flag, err_pos});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send the top nbits of cw (c14 first), waiting for in_ready on each bit.
    task automatic send_bits(input logic [14:0] cw, input int nbits);
        for (int i = 14; i > 14 - nbits; i--) begin
            logic rdy;
            int   n;
            rdy      = 1'b0;
            n        = 0;
            in_valid = 1'b1;
            in_bit   = cw[i];
            while (!rdy && n < 100) begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            check("send_accept", 32'(rdy), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    // Pop one 11-bit frame from the collected output stream and check it.
    task automatic check_frame(input string tag, input logic [10:0] exp_data,
                               input logic exp_err, input logic [3:0] exp_pos);
        logic [10:0] data;
        logic [10:0] lastv;
        logic [10:0] errv;
        logic [3:0]  pos;
        logic        ok;
        item_t       it;
        for (int n = 0; n < 400 && q.size() < 11; n++) begin
            @(posedge clk);
        end
        #1;
        ok = (q.size() >= 11);
        check({tag, "_timeout"}, 32'(ok), 32'd1);
        if (ok) begin
            data  = '0;
            lastv = '0;
            errv  = '0;
            pos   = '0;
            for (int k = 0; k < 11; k++) begin
                it    = q.pop_front();
                data  = {data[9:0], it.b};
                lastv = {lastv[9:0], it.last};
                errv  = {errv[9:0], it.err};
                if (k == 0) pos = it.pos;
            end
            check({tag, "_data"}, 32'(data), 32'(exp_data));
            check({tag, "_last"}, 32'(lastv), 32'h001);
            check({tag, "_err"}, 32'(errv), exp_err ? 32'h7FF : 32'h000);
            if (exp_err) begin
                check({tag, "_pos"}, 32'(pos), 32'(exp_pos));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_outs", 32'({out_valid, out_bit, out_last, err_flag, err_pos}), 32'd0);
        @(posedge clk);
        #1;

        // 1: all-zero codeword and first-output latency
        send_bits(15'h0000, 15);
        check("t1_in_ready_stall", 32'(in_ready), 32'd0);
        check("t1_out_valid_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t1_out_valid_latency", 32'(out_valid), 32'd1);
        check("t1_in_ready_back", 32'(in_ready), 32'd1);
        check_frame("t1", 11'h000, 1'b0, 4'd0);

        // 2: clean codeword g(x) itself
        send_bits(15'b000_0000_0001_0011, 15);
        check_frame("t2", 11'b000_0000_0001, 1'b0, 4'd0);

        // 3: c4 flipped -> s=0011, p=4
        send_bits(15'b000_0000_0000_0011, 15);
        check_frame("t3", 11'b000_0000_0001, 1'b1, 4'd4);

        // 4: boundary positions on the all-zero codeword
        send_bits(15'h4000, 15);
        check_frame("t4_c14", 11'h000, 1'b1, 4'd14);
        send_bits(15'h0001, 15);
        check_frame("t4_c0", 11'h000, 1'b1, 4'd0);

        // Parity-bit error (c1): data unchanged, flag set
        send_bits(15'b000_0000_0001_0001, 15);
        check_frame("par_c1", 11'b000_0000_0001, 1'b1, 4'd1);

        // x^10 g(x) with c9 flipped -> s=1010, p=9
        send_bits(15'b100_1110_0000_0000, 15);
        check_frame("c9", 11'b100_1100_0000, 1'b1, 4'd9);

`ifdef CYC_DEC_ERR_STATS_EN
        check("stats_before_reset", 32'(err_count), 32'd5);
`endif

        // 5: back-to-back frames under backpressure
        out_ready = 1'b0;
        send_bits(15'b100_1100_0000_0000, 15);
        send_bits(15'b000_0000_0001_0011, 15);
        check("t5_in_ready_full", 32'(in_ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_in_ready_held", 32'(in_ready), 32'd0);
        check("t5_hold_outs", 32'({out_valid, out_bit, out_last, err_flag}), 32'b1100);
        out_ready = 1'b1;
        check_frame("t5_a", 11'b100_1100_0000, 1'b0, 4'd0);
        check_frame("t5_b", 11'b000_0000_0001, 1'b0, 4'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_extra", 32'(q.size()), 32'd0);

        // 6: reset in the middle of a frame, then a clean frame
        send_bits(15'h7FFF, 7);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", 32'({out_valid, out_bit, out_last, err_flag, err_pos}), 32'd0);
`ifdef CYC_DEC_ERR_STATS_EN
        check("t6_stats_cleared", 32'(err_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        send_bits(15'b000_0000_0001_0011, 15);
        check_frame("t6_clean", 11'b000_0000_0001, 1'b0, 4'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t6_only_clean", 32'(q.size()), 32'd0);

        send_bits(15'b000_0000_0000_0011, 15);
        check_frame("t6_e1", 11'b000_0000_0001, 1'b1, 4'd4);
        send_bits(15'h4000, 15);
        check_frame("t6_e2", 11'h000, 1'b1, 4'd14);
        send_bits(15'h0001, 15);
        check_frame("t6_e3", 11'h000, 1'b1, 4'd0);
        @(posedge clk);
        #1;
`ifdef CYC_DEC_ERR_STATS_EN
        check("t6_stats_three", 32'(err_count), 32'd3);
`endif

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
